// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: request-to-send inhibit, LSB-first shift with odd parity
// on device clock falls, acknowledge check and inter-fall timeout. Pins are driven via open-drain enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 1200,
    parameter int TIMEOUT_CYCLES = 180000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_ok,
    output logic       o_err,
    output logic [2:0] o_state
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_REQ     = 3'd2,
        S_DATA    = 3'd3,
        S_PAR     = 3'd4,
        S_ACK     = 3'd5,
        S_WAIT    = 3'd6
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    logic             clk_meta_p0, clk_sync_p1, clk_last_p2;
    logic             dat_meta_p0, dat_sync_p1;
    logic             fall, wait_ok;

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       data_r, data_n;
    logic             ack_r, ack_n;
    logic             clk_oe_n, dat_oe_n, busy_n, done_n, err_n, ack_ok_n;

    // Pin synchronizers (p0, p1) and the previous synced clock for edge detection (p2)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_meta_p0 <= 1'b0;
            clk_sync_p1 <= 1'b0;
            clk_last_p2 <= 1'b0;
            dat_meta_p0 <= 1'b0;
            dat_sync_p1 <= 1'b0;
        end else begin
            clk_meta_p0 <= i_ps2_clk;
            clk_sync_p1 <= clk_meta_p0;
            clk_last_p2 <= clk_sync_p1;
            dat_meta_p0 <= i_ps2_dat;
            dat_sync_p1 <= dat_meta_p0;
        end
    end

    assign fall    = clk_last_p2 & ~clk_sync_p1;
    assign wait_ok = clk_sync_p1 & dat_sync_p1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            timer        <= '0;
            bit_cnt      <= '0;
            data_r       <= '0;
            ack_r        <= 1'b0;
            o_ps2_clk_oe <= 1'b0;
            o_ps2_dat_oe <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_ack_ok     <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            bit_cnt      <= bit_cnt_n;
            data_r       <= data_n;
            ack_r        <= ack_n;
            o_ps2_clk_oe <= clk_oe_n;
            o_ps2_dat_oe <= dat_oe_n;
            o_busy       <= busy_n;
            o_done       <= done_n;
            o_err        <= err_n;
            o_ack_ok     <= ack_ok_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer + CNT_W'(1);
        bit_cnt_n = bit_cnt;
        data_n    = data_r;
        ack_n     = ack_r;
        clk_oe_n  = o_ps2_clk_oe;
        dat_oe_n  = o_ps2_dat_oe;
        busy_n    = o_busy;
        done_n    = 1'b0;
        err_n     = 1'b0;
        ack_ok_n  = o_ack_ok;

        unique case (state)
            S_IDLE: begin
                // busy stays up through the done cycle so a start there is refused
                timer_n = '0;
                busy_n  = 1'b0;
                if (i_start && !o_busy) begin
                    data_n    = i_data;
                    bit_cnt_n = '0;
                    ack_n     = 1'b0;
                    ack_ok_n  = 1'b0;
                    clk_oe_n  = 1'b1;
                    dat_oe_n  = 1'b0;
                    busy_n    = 1'b1;
                    state_n   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (timer == INH_LAST) begin
                    clk_oe_n = 1'b0;
                    dat_oe_n = 1'b1;
                    timer_n  = '0;
                    state_n  = S_REQ;
                end
            end
            default: begin
                if (fall) begin
                    timer_n = '0;
                end
                if (state == S_WAIT && wait_ok) begin
                    done_n   = 1'b1;
                    ack_ok_n = ack_r;
                    clk_oe_n = 1'b0;
                    dat_oe_n = 1'b0;
                    timer_n  = '0;
                    state_n  = S_IDLE;
                end else if (fall) begin
                    case (state)
                        S_REQ: begin
                            dat_oe_n  = ~data_r[0];
                            bit_cnt_n = 4'd1;
                            state_n   = S_DATA;
                        end
                        S_DATA: begin
                            bit_cnt_n = bit_cnt + 4'd1;
                            if (bit_cnt == 4'd8) begin
                                dat_oe_n = ~odd_parity(data_r);
                                state_n  = S_PAR;
                            end else begin
                                dat_oe_n = ~data_r[bit_cnt[2:0]];
                            end
                        end
                        S_PAR: begin
                            dat_oe_n  = 1'b0;
                            bit_cnt_n = 4'd10;
                            state_n   = S_ACK;
                        end
                        S_ACK: begin
                            ack_n   = ~dat_sync_p1;
                            state_n = S_WAIT;
                        end
                        default: ;
                    endcase
                end else if (timer == TO_LAST) begin
                    clk_oe_n = 1'b0;
                    dat_oe_n = 1'b0;
                    done_n   = 1'b1;
                    err_n    = 1'b1;
                    ack_ok_n = 1'b0;
                    timer_n  = '0;
                    state_n  = S_IDLE;
                end
            end
        endcase
    end

    assign o_state = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames, a scoreboard queue checks each o_done.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 500;
    localparam int H   = 10;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_ps2_clk_oe, o_ps2_dat_oe, o_busy, o_done, o_ack_ok, o_err;
    logic [2:0] o_state;
    logic       clk_line, dat_line;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic [9:0] rx_bits = '0;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    typedef struct packed {
        logic ack_ok;
        logic err;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    typedef struct packed {
        logic [7:0] data;
        logic       dev_ack;
        logic       exp_par;
        logic       exp_ack_ok;
    } vec_t;
    vec_t vecs[5];

    assign clk_line = ~(o_ps2_clk_oe | dev_clk_low);
    assign dat_line = ~(o_ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_data       (i_data),
        .i_ps2_clk    (clk_line),
        .i_ps2_dat    (dat_line),
        .o_ps2_clk_oe (o_ps2_clk_oe),
        .o_ps2_dat_oe (o_ps2_dat_oe),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_ack_ok     (o_ack_ok),
        .o_err        (o_err),
        .o_state      (o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && o_done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got o_done=1, expected no transfer end");
            end else begin
                mon_e = sb_q.pop_front();
                check("done_ack_ok", o_ack_ok, mon_e.ack_ok);
                check("done_err", o_err, mon_e.err);
                check("done_busy", o_busy, 1);
            end
        end
    end

    task automatic pulse_start(input logic [7:0] d);
        @(negedge i_clk);
        i_data  = d;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Device: waits for start bit, generates nf falls, samples line on each rise, acks before fall 11
    task automatic device(input logic ack, input int nf);
        int guard = 0;
        while (!(clk_line && !dat_line) && guard < 200) begin
            @(negedge i_clk);
            guard++;
        end
        if (guard >= 200) check("dev_start_seen", 0, 1);
        for (int k = 1; k <= nf; k++) begin
            repeat (H) @(negedge i_clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge i_clk);
            if (k <= 10) rx_bits[k-1] = dat_line;
            dev_clk_low = 1'b0;
            if (k == 10 && ack) dev_dat_low = 1'b1;
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic ack, input logic exp_par,
                              input logic exp_ack, input logic inject);
        int n;
        int start_cnt;
        exp_t e;
        e.ack_ok = exp_ack;
        e.err    = 1'b0;
        sb_q.push_back(e);
        start_cnt = done_cnt;
        pulse_start(d);
        check("acc_clk_oe", o_ps2_clk_oe, 1);
        check("acc_dat_oe", o_ps2_dat_oe, 0);
        check("acc_busy", o_busy, 1);
        check("acc_state", o_state, 1);
        n = 0;
        while (o_ps2_clk_oe && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check("inhibit_len", n, INH);
        check("req_dat_oe", o_ps2_dat_oe, 1);
        check("req_state", o_state, 2);
        fork
            device(ack, 11);
            begin
                if (inject) begin
                    repeat (60) @(negedge i_clk);
                    i_data  = 8'h12;
                    i_start = 1'b1;
                    @(negedge i_clk);
                    i_start = 1'b0;
                end
            end
        join
        n = 0;
        while (!o_done && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) check("done_timeout", 0, 1);
        if (inject) begin
            i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
        end
        repeat (5) @(negedge i_clk);
        check("done_count", done_cnt - start_cnt, 1);
        check("post_busy", o_busy, 0);
        check("post_state", o_state, 0);
        check("hold_ack_ok", o_ack_ok, exp_ack);
        check("post_oe", {o_ps2_clk_oe, o_ps2_dat_oe}, 0);
        check("line_data", rx_bits[7:0], d);
        check("line_parity", rx_bits[8], exp_par);
        check("line_stop", rx_bits[9], 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        exp_t e;
        vecs[0] = '{data: 8'hED, dev_ack: 1'b1, exp_par: 1'b1, exp_ack_ok: 1'b1};
        vecs[1] = '{data: 8'hF4, dev_ack: 1'b1, exp_par: 1'b0, exp_ack_ok: 1'b1};
        vecs[2] = '{data: 8'hFF, dev_ack: 1'b0, exp_par: 1'b1, exp_ack_ok: 1'b0};
        vecs[3] = '{data: 8'h00, dev_ack: 1'b1, exp_par: 1'b1, exp_ack_ok: 1'b1};
        vecs[4] = '{data: 8'h80, dev_ack: 1'b1, exp_par: 1'b0, exp_ack_ok: 1'b1};

        repeat (3) @(negedge i_clk);
        check("rst_outputs", {o_ps2_clk_oe, o_ps2_dat_oe, o_busy, o_done, o_ack_ok, o_err}, 0);
        check("rst_state", o_state, 0);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        check("idle_state", o_state, 0);

        for (int i = 0; i < 5; i++)
            send_frame(vecs[i].data, vecs[i].dev_ack, vecs[i].exp_par, vecs[i].exp_ack_ok, 1'b0);

        // Start requests mid-frame and in the done cycle must both be refused
        send_frame(8'hED, 1'b1, 1'b1, 1'b1, 1'b1);

        // Device never clocks: timeout counted from S_REQ entry
        e.ack_ok = 1'b0;
        e.err    = 1'b1;
        sb_q.push_back(e);
        pulse_start(8'hA5);
        n = 0;
        while (o_state != 3'd2 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("to_req_reached", o_state, 2);
        n = 0;
        while (!o_done && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        check("to_latency", n, TO);
        check("to_err", o_err, 1);
        check("to_oe", {o_ps2_clk_oe, o_ps2_dat_oe}, 0);
        check("to_state", o_state, 0);
        repeat (3) @(negedge i_clk);
        check("to_idle_busy", o_busy, 0);

        // Asynchronous reset after the 5th fall releases both lines immediately
        pulse_start(8'hED);
        device(1'b1, 5);
        check("mid_dat_oe", o_ps2_dat_oe, 1);
        check("mid_state", o_state, 3);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_oe", {o_ps2_clk_oe, o_ps2_dat_oe}, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("arst_state", o_state, 0);
        check("arst_busy", o_busy, 0);
        check("arst_done", o_done, 0);
        send_frame(8'hED, 1'b1, 1'b1, 1'b1, 1'b0);

        check("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
